// File: rtl/pcie_fb_pkg.sv
// Shared constants and types for the PCIe frame-buffer write path.
// The DEF_* constants are the default build configuration.
package pcie_fb_pkg;

    localparam int unsigned DEF_PIX_W    = 16;
    localparam int unsigned DEF_DATA_W   = 256;
    localparam int unsigned DEF_ADDR_W   = 9;
    localparam int unsigned PIX_PER_WORD = DEF_DATA_W / DEF_PIX_W;
    localparam int unsigned BANK_WORDS   = 2 ** (DEF_ADDR_W - 1);

    typedef enum logic {FILL, STALL} wr_state_e;

    typedef logic                    bank_id_t;
    typedef logic [DEF_ADDR_W-2:0]   word_idx_t;

endpackage

// File: rtl/pcie_fram_buf_writer_if.sv
// Pixel stream, RAM write port and bank hand-off signals of the frame-buffer writer.
// The master modport is the writer; the slave modport is its source/RAM/DMA environment.
interface pcie_fram_buf_writer_if #(
    parameter int unsigned PIX_W  = 16,
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 9
);
    logic              pix_vld;
    logic              pix_rdy;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_sof;
    logic              pix_eol;
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic              bank_rdy;
    logic              bank_id;
    logic [ADDR_W-1:0] bank_len;
    logic [1:0]        bank_full;
    logic [1:0]        bank_rel;
    logic              sof_drop;

    modport master (
        input  pix_vld, pix_data, pix_sof, pix_eol, bank_rel,
        output pix_rdy, ram_wr_en, ram_wr_addr, ram_wr_data,
               bank_rdy, bank_id, bank_len, bank_full, sof_drop
    );

    modport slave (
        output pix_vld, pix_data, pix_sof, pix_eol, bank_rel,
        input  pix_rdy, ram_wr_en, ram_wr_addr, ram_wr_data,
               bank_rdy, bank_id, bank_len, bank_full, sof_drop
    );

endinterface

// File: rtl/pix_word_packer.sv
// Packs accepted pixels LSB-first into RAM words; emits a completed word one cycle after its last pixel.
// FB_WR_BSWAP_EN byte-swaps each pixel before packing.
module pix_word_packer
    import pcie_fb_pkg::*;
#(
    parameter int unsigned PIX_W  = DEF_PIX_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              wr_clk,
    input  logic              tb_wr_rst,
    input  logic              accept,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              pix_sof,
    input  logic              pix_eol,
    output logic              partial,
    output logic              word_vld,
    output logic [DATA_W-1:0] word_data,
    output logic              word_eol
);

    localparam int unsigned PixPerWord = DATA_W / PIX_W;
    localparam int unsigned SlotW      = $clog2(PixPerWord);

    logic [SlotW-1:0]  slot_q, slot_d, slot_eff;
    logic [DATA_W-1:0] acc_q, acc_d, merged, word_q, word_d;
    logic              vld_q, vld_d, eol_q, eol_d;
    logic [PIX_W-1:0]  pix;
    logic              last;

`ifdef FB_WR_BSWAP_EN
    assign pix = {pix_data[7:0], pix_data[PIX_W-1:8]};
`else
    assign pix = pix_data;
`endif

    // sof restarts the word, so the pixel lands in slot 0 of an empty accumulator
    always_comb begin
        slot_eff = pix_sof ? '0 : slot_q;
        merged   = pix_sof ? '0 : acc_q;
        merged[PIX_W*slot_eff +: PIX_W] = pix;
        last     = (slot_eff == SlotW'(PixPerWord - 1)) || pix_eol;
        slot_d   = slot_q;
        acc_d    = acc_q;
        vld_d    = 1'b0;
        eol_d    = eol_q;
        word_d   = word_q;
        if (accept) begin
            if (last) begin
                slot_d = '0;
                acc_d  = '0;
                vld_d  = 1'b1;
                eol_d  = pix_eol;
                word_d = merged;
            end else begin
                slot_d = slot_eff + 1'b1;
                acc_d  = merged;
            end
        end
    end

    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            slot_q <= '0;
            acc_q  <= '0;
            vld_q  <= 1'b0;
            eol_q  <= 1'b0;
            word_q <= '0;
        end else begin
            slot_q <= slot_d;
            acc_q  <= acc_d;
            vld_q  <= vld_d;
            eol_q  <= eol_d;
            word_q <= word_d;
        end
    end

    assign partial   = (slot_q != '0);
    assign word_vld  = vld_q;
    assign word_data = word_q;
    assign word_eol  = eol_q;

endmodule

// File: rtl/pcie_fram_buf_writer.sv
// Frame-buffer writer: packs pixels into two ping-pong RAM banks and hands closed banks to the DMA side.
// Define FB_WR_BSWAP_EN to byte-swap pixels (host-endian RGB565) before packing.
module pcie_fram_buf_writer
    import pcie_fb_pkg::*;
#(
    parameter int unsigned PIX_W             = DEF_PIX_W,
    parameter int unsigned DATA_W            = DEF_DATA_W,
    parameter int unsigned ADDR_W            = DEF_ADDR_W,
    parameter bit          BANK_CLOSE_ON_EOL = 1'b1
) (
    input  logic                   wr_clk,
    input  logic                   tb_wr_rst,
    pcie_fram_buf_writer_if.master bus
);

    localparam int unsigned IdxW    = ADDR_W - 1;
    localparam logic [IdxW-1:0] LastIdx = '1;

    logic              accept, partial, word_vld, word_eol;
    logic [DATA_W-1:0] word_data;
    wr_state_e         state_q, state_d;
    bank_id_t          cur_bank_q, cur_bank_d;
    logic [IdxW-1:0]   word_idx_q, word_idx_d, idx_after_wr;
    logic [1:0]        bank_full_q, bank_full_d;
    logic              bank_rdy_q, bank_rdy_d, bank_id_q, bank_id_d;
    logic [ADDR_W-1:0] bank_len_q, bank_len_d;
    logic              sof_drop_q, sof_drop_d;
    logic              close, stall_next;

    assign accept = bus.pix_vld & bus.pix_rdy;

    pix_word_packer #(
        .PIX_W (PIX_W),
        .DATA_W(DATA_W)
    ) u_packer (
        .wr_clk   (wr_clk),
        .tb_wr_rst(tb_wr_rst),
        .accept   (accept),
        .pix_data (bus.pix_data),
        .pix_sof  (bus.pix_sof),
        .pix_eol  (bus.pix_eol),
        .partial  (partial),
        .word_vld (word_vld),
        .word_data(word_data),
        .word_eol (word_eol)
    );

    // The close is decided while the word sits on the write port, so the
    // address and the bank bookkeeping advance on the same edge as the write.
    assign close = word_vld && ((word_idx_q == LastIdx) || (BANK_CLOSE_ON_EOL && word_eol));

    always_comb begin
        bank_full_d = bank_full_q & ~bus.bank_rel;
        if (close) bank_full_d[cur_bank_q] = 1'b1;
        stall_next   = close && bank_full_d[~cur_bank_q];
        idx_after_wr = word_vld ? (close ? '0 : word_idx_q + 1'b1) : word_idx_q;
        cur_bank_d   = close ? ~cur_bank_q : cur_bank_q;
        sof_drop_d   = accept && bus.pix_sof && (partial || (idx_after_wr != '0));
        word_idx_d   = (accept && bus.pix_sof) ? '0 : idx_after_wr;
        bank_rdy_d   = close;
        bank_id_d    = close ? cur_bank_q : bank_id_q;
        bank_len_d   = close ? ADDR_W'(word_idx_q) + ADDR_W'(1) : bank_len_q;
    end

    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:    if (stall_next) state_d = STALL;
            STALL:   if (bus.bank_rel[cur_bank_q]) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Also hold off while a closing word is on the port and the other bank is
    // still owned, so an eol pixel cannot complete a word into a full bank.
    always_comb begin
        bus.pix_rdy = 1'b0;
        if (!tb_wr_rst && (state_q == FILL) && !bank_full_q[cur_bank_q] &&
            !(close && bank_full_q[~cur_bank_q])) begin
            bus.pix_rdy = 1'b1;
        end
    end

    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            cur_bank_q  <= 1'b0;
            word_idx_q  <= '0;
            bank_full_q <= '0;
            bank_rdy_q  <= 1'b0;
            bank_id_q   <= 1'b0;
            bank_len_q  <= '0;
            sof_drop_q  <= 1'b0;
        end else begin
            cur_bank_q  <= cur_bank_d;
            word_idx_q  <= word_idx_d;
            bank_full_q <= bank_full_d;
            bank_rdy_q  <= bank_rdy_d;
            bank_id_q   <= bank_id_d;
            bank_len_q  <= bank_len_d;
            sof_drop_q  <= sof_drop_d;
        end
    end

    assign bus.ram_wr_en   = word_vld;
    assign bus.ram_wr_addr = {cur_bank_q, word_idx_q};
    assign bus.ram_wr_data = word_data;
    assign bus.bank_rdy    = bank_rdy_q;
    assign bus.bank_id     = bank_id_q;
    assign bus.bank_len    = bank_len_q;
    assign bus.bank_full   = bank_full_q;
    assign bus.sof_drop    = sof_drop_q;

endmodule

// File: tb/tb_pcie_fram_buf_writer.sv
// Self-checking bench for pcie_fram_buf_writer: a pixel-level model queues expected RAM writes
// and bank closes, which monitors pop and compare as the DUT produces them.
module tb_pcie_fram_buf_writer;
    import pcie_fb_pkg::*;

    typedef struct packed {
        logic [8:0]   addr;
        logic [255:0] data;
    } wr_t;

    typedef struct packed {
        logic       id;
        logic [8:0] len;
    } bk_t;

    logic wr_clk = 1'b0;
    logic tb_wr_rst;

    always #5 wr_clk = ~wr_clk;

    pcie_fram_buf_writer_if #(.PIX_W(16), .DATA_W(256), .ADDR_W(9)) bus ();

    pcie_fram_buf_writer #(
        .PIX_W            (16),
        .DATA_W           (256),
        .ADDR_W           (9),
        .BANK_CLOSE_ON_EOL(1'b1)
    ) dut (
        .wr_clk   (wr_clk),
        .tb_wr_rst(tb_wr_rst),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;
    wr_t wq[$];
    bk_t bq[$];
    int n_wr = 0;
    int n_drop = 0;
    int exp_drop = 0;
    logic [255:0] last_data = '0;

    int           m_slot;
    int           m_idx;
    logic         m_bank;
    logic [255:0] m_acc;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_slot = 0;
        m_idx  = 0;
        m_bank = 1'b0;
        m_acc  = '0;
    endtask

    task automatic model_accept(input logic [15:0] d, input logic sof, input logic eol);
        logic [15:0] p;
`ifdef FB_WR_BSWAP_EN
        p = {d[7:0], d[15:8]};
`else
        p = d;
`endif
        if (sof) begin
            if (m_slot != 0 || m_idx != 0) exp_drop++;
            m_acc  = '0;
            m_slot = 0;
            m_idx  = 0;
        end
        m_acc[16*m_slot +: 16] = p;
        if (m_slot == 15 || eol) begin
            wq.push_back({m_bank, 8'(m_idx), m_acc});
            if (m_idx == 255 || eol) begin
                bq.push_back({m_bank, 9'(m_idx + 1)});
                m_bank = ~m_bank;
                m_idx  = 0;
            end else begin
                m_idx++;
            end
            m_acc  = '0;
            m_slot = 0;
        end else begin
            m_slot++;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_pix(input logic [15:0] d, input logic sof, input logic eol);
        int n = 0;
        bus.pix_vld  = 1'b1;
        bus.pix_data = d;
        bus.pix_sof  = sof;
        bus.pix_eol  = eol;
        while (!bus.pix_rdy && n < 3000) begin
            @(negedge wr_clk);
            n++;
        end
        if (!bus.pix_rdy) begin
            chk("rdy_timeout", 256'(bus.pix_rdy), 256'(1));
            bus.pix_vld = 1'b0;
            return;
        end
        @(posedge wr_clk);
        model_accept(d, sof, eol);
        @(negedge wr_clk);
        bus.pix_vld = 1'b0;
        bus.pix_sof = 1'b0;
        bus.pix_eol = 1'b0;
    endtask

    task automatic send_n(input int n);
        for (int i = 0; i < n; i++) send_pix(16'($urandom), 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        bus.pix_vld = 1'b0;
        repeat (n) @(negedge wr_clk);
    endtask

    task automatic do_reset();
        tb_wr_rst    = 1'b1;
        bus.pix_vld  = 1'b0;
        bus.pix_data = '0;
        bus.pix_sof  = 1'b0;
        bus.pix_eol  = 1'b0;
        bus.bank_rel = 2'b00;
        model_reset();
        wq.delete();
        bq.delete();
        n_drop   = 0;
        exp_drop = 0;
        repeat (2) @(negedge wr_clk);
        chk("rst_pix_rdy", 256'(bus.pix_rdy), 256'(0));
        chk("rst_ram_wr_en", 256'(bus.ram_wr_en), 256'(0));
        chk("rst_bank_full", 256'(bus.bank_full), 256'(0));
        tb_wr_rst = 1'b0;
        @(negedge wr_clk);
    endtask

    task automatic end_test(input string name);
        idle(4);
        chk({name, "_wq_empty"}, 256'(wq.size()), 256'(0));
        chk({name, "_bq_empty"}, 256'(bq.size()), 256'(0));
        chk({name, "_sof_drop"}, 256'(n_drop), 256'(exp_drop));
    endtask

    always @(posedge wr_clk) begin : mon
        wr_t e;
        bk_t b;
        #1;
        if (!tb_wr_rst) begin
            if (bus.ram_wr_en) begin
                n_wr++;
                last_data = bus.ram_wr_data;
                chk("wr_expected", 256'(wq.size() > 0), 256'(1));
                if (wq.size() > 0) begin
                    e = wq.pop_front();
                    chk("wr_addr", 256'(bus.ram_wr_addr), 256'(e.addr));
                    chk("wr_data", bus.ram_wr_data, e.data);
                end
            end
            if (bus.bank_rdy) begin
                chk("bank_expected", 256'(bq.size() > 0), 256'(1));
                if (bq.size() > 0) begin
                    b = bq.pop_front();
                    chk("bank_id", 256'(bus.bank_id), 256'(b.id));
                    chk("bank_len", 256'(bus.bank_len), 256'(b.len));
                end
            end
            if (bus.sof_drop) n_drop++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        tb_wr_rst = 1'b1;
        @(negedge wr_clk);

        // full bank without eol, then first word of bank 1
        do_reset();
        send_n(4096);
        idle(3);
        chk("t1_bank_full", 256'(bus.bank_full), 256'(2'b01));
        send_n(16);
        end_test("t1");

        // 20 pixels, eol on the last: one full word plus a 4-pixel word, bank closes
        do_reset();
        for (int i = 0; i < 20; i++) send_pix(16'($urandom), 1'b0, i == 19);
        end_test("t2");
        chk("t2_bank_full", 256'(bus.bank_full), 256'(2'b01));

        // both banks full without release -> stall until bank 0 is released
        do_reset();
        send_n(8192);
        idle(5);
        chk("t3_rdy_low", 256'(bus.pix_rdy), 256'(0));
        chk("t3_state", 256'(dut.state_q), 256'(STALL));
        chk("t3_bank_full", 256'(bus.bank_full), 256'(2'b11));
        n0 = n_wr;
        idle(10);
        chk("t3_no_wr", 256'(n_wr), 256'(n0));
        bus.bank_rel = 2'b01;
        @(negedge wr_clk);
        bus.bank_rel = 2'b00;
        chk("t3_rdy_back", 256'(bus.pix_rdy), 256'(1));
        send_n(16);
        end_test("t3");
        chk("t3_full_after", 256'(bus.bank_full), 256'(2'b10));

        // sof on a clean start, then sof mid-word and mid-bank
        do_reset();
        send_pix(16'($urandom), 1'b1, 1'b0);
        send_n(36);
        send_pix(16'($urandom), 1'b1, 1'b0);
        send_n(15);
        end_test("t4");
        chk("t4_drops", 256'(n_drop), 256'(1));

        // asynchronous reset mid-bank
        do_reset();
        send_n(1600);
        idle(2);
        #2 tb_wr_rst = 1'b1;
        #1;
        chk("t5_rdy", 256'(bus.pix_rdy), 256'(0));
        chk("t5_full", 256'(bus.bank_full), 256'(0));
        chk("t5_wr_en", 256'(bus.ram_wr_en), 256'(0));
        chk("t5_addr", 256'(bus.ram_wr_addr), 256'(0));
        chk("t5_bank_rdy", 256'(bus.bank_rdy), 256'(0));
        @(negedge wr_clk);
        do_reset();
        send_n(16);
        end_test("t5");

        // pixel packing order / byte swap, and sof+eol on one pixel
        do_reset();
        send_pix(16'h1234, 1'b0, 1'b1);
        idle(3);
`ifdef FB_WR_BSWAP_EN
        chk("t6_bswap", 256'(last_data[15:0]), 256'(16'h3412));
`else
        chk("t6_nobswap", 256'(last_data[15:0]), 256'(16'h1234));
`endif
        send_n(3);
        send_pix(16'($urandom), 1'b1, 1'b1);
        end_test("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
